ram_bist_sequencer: RTL and testbench

- Built-in self-test stage for the on-chip dual-port 32-bit RAM. It drives port A, the write side, and consumes port B, the registered read side.
- On `start` it runs two passes. Each pass fills every address with a known pattern, then reads every address back and compares.
- Status is reported through `busy`, `done`, `error` and capture registers, which the top level maps onto the board LEDs.

---
 rtl/ram_bist_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ram_bist_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_sequencer.sv
// ram_bist_sequencer: two-pass march-style self-test for a dual-port 32-bit RAM.
// Port A (write side) is filled with P(a,p) = a ^ SEED ^ {32{p}}; port B (registered
// read side) is read back through a one-stage compare pipeline.
// Optional feature macro: RAM_BIST_ERRCNT_EN adds err_count and runs both passes
// to completion, counting every mismatch instead of aborting on the first.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start, RAM ports quiet
// S_FILL   | writing P(k, pass) to every address, one per cycle
// S_VERIFY | issuing reads 0..N-1, then one drain cycle for the last compare
// S_PASS   | test finished clean, done held until start/reset
// S_FAIL   | test finished with a mismatch, capture registers held
`timescale 1ns/1ps

module ram_bist_sequencer #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] SEED       = 32'h5A5A_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [31:0]           ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [31:0]           ram_dout_b,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [31:0]           err_data,
  output logic                  pass_id
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_PASS, S_FAIL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] next_cnt;
  logic                  pass;
  logic                  drain;
  logic                  chk_vld;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  mismatch;
`ifdef RAM_BIST_ERRCNT_EN
  logic                  err_pass;
`endif

  function automatic logic [31:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic p);
    return 32'(a) ^ SEED ^ {32{p}};
  endfunction

  assign next_cnt = cnt + 1'b1;

  // Compare the word returned for the address issued one cycle earlier
  assign mismatch = (state == S_VERIFY) && chk_vld && (ram_dout_b != pattern(chk_addr, pass));

  // Sequencer: fill/verify passes, compare pipeline, status and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pass       <= 1'b0;
      drain      <= 1'b0;
      chk_vld    <= 1'b0;
      chk_addr   <= '0;
      ram_we     <= 4'h0;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
      ram_addr_b <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
      err_data   <= '0;
      pass_id    <= 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
      err_count  <= '0;
      err_pass   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            state      <= S_FILL;
            pass       <= 1'b0;
            pass_id    <= 1'b0;
            cnt        <= '0;
            chk_vld    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
            err_data   <= '0;
            ram_we     <= 4'hF;
            ram_addr_a <= '0;
            ram_din_a  <= pattern('0, 1'b0);
`ifdef RAM_BIST_ERRCNT_EN
            err_count  <= '0;
            err_pass   <= 1'b0;
`endif
          end
        end

        S_FILL: begin
          if (cnt == LAST_ADDR) begin
            ram_we     <= 4'h0;
            state      <= S_VERIFY;
            cnt        <= '0;
            drain      <= 1'b0;
            chk_vld    <= 1'b0;
            ram_addr_b <= '0;
          end else begin
            cnt        <= next_cnt;
            ram_addr_a <= next_cnt;
            ram_din_a  <= pattern(next_cnt, pass);
          end
        end

        S_VERIFY: begin
          if (!drain) begin
            chk_addr <= cnt;
            chk_vld  <= 1'b1;
            if (cnt == LAST_ADDR) begin
              drain <= 1'b1;
            end else begin
              cnt        <= next_cnt;
              ram_addr_b <= next_cnt;
            end
          end else begin
            chk_vld <= 1'b0;
          end
`ifdef RAM_BIST_ERRCNT_EN
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) begin
              err_addr <= chk_addr;
              err_data <= ram_dout_b;
              err_pass <= pass;
            end
          end
          if (drain) begin
            if (!pass) begin
              pass       <= 1'b1;
              pass_id    <= 1'b1;
              state      <= S_FILL;
              cnt        <= '0;
              ram_we     <= 4'hF;
              ram_addr_a <= '0;
              ram_din_a  <= pattern('0, 1'b1);
            end else begin
              state   <= ((err_count != 16'd0) || mismatch) ? S_FAIL : S_PASS;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= (err_count != 16'd0) || mismatch;
              pass_id <= (err_count != 16'd0) ? err_pass : pass;
            end
          end
`else
          if (mismatch) begin
            state    <= S_FAIL;
            busy     <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            err_addr <= chk_addr;
            err_data <= ram_dout_b;
          end else if (drain) begin
            if (!pass) begin
              pass       <= 1'b1;
              pass_id    <= 1'b1;
              state      <= S_FILL;
              cnt        <= '0;
              ram_we     <= 4'hF;
              ram_addr_a <= '0;
              ram_din_a  <= pattern('0, 1'b1);
            end else begin
              state <= S_PASS;
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b0;
            end
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Directed bench for ram_bist_sequencer: an 8-word instance with a fault-injectable
// RAM model and a default 512-word instance for the full-size latency check.
`timescale 1ns/1ps

module tb_ram_bist_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start9;

  logic [3:0]  ram_we3, ram_we9;
  logic [2:0]  addr_a3, addr_b3, err_addr3;
  logic [8:0]  addr_a9, addr_b9, err_addr9;
  logic [31:0] din3, din9, dout3, dout9, err_data3, err_data9;
  logic        busy3, done3, error3, pass_id3;
  logic        busy9, done9, error9, pass_id9;
`ifdef RAM_BIST_ERRCNT_EN
  logic [15:0] err_count3, err_count9;
`endif

  logic [31:0] mem3 [0:7];
  logic [31:0] mem9 [0:511];
  logic [2:0]  f_addr;
  logic [31:0] f_clr, f_set;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_bist_sequencer #(.ADDR_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .ram_we(ram_we3), .ram_addr_a(addr_a3), .ram_din_a(din3),
    .ram_addr_b(addr_b3), .ram_dout_b(dout3),
    .busy(busy3), .done(done3), .error(error3),
    .err_addr(err_addr3), .err_data(err_data3), .pass_id(pass_id3)
`ifdef RAM_BIST_ERRCNT_EN
    , .err_count(err_count3)
`endif
  );

  ram_bist_sequencer dut9 (
    .clk(clk), .rst(rst), .start(start9),
    .ram_we(ram_we9), .ram_addr_a(addr_a9), .ram_din_a(din9),
    .ram_addr_b(addr_b9), .ram_dout_b(dout9),
    .busy(busy9), .done(done9), .error(error9),
    .err_addr(err_addr9), .err_data(err_data9), .pass_id(pass_id9)
`ifdef RAM_BIST_ERRCNT_EN
    , .err_count(err_count9)
`endif
  );

  // Small RAM: byte-enabled write, registered read with a stuck-bit fault on one address
  always @(posedge clk) begin
    logic [31:0] rd;
    for (int i = 0; i < 4; i++)
      if (ram_we3[i]) mem3[addr_a3][8*i +: 8] <= din3[8*i +: 8];
    rd = mem3[addr_b3];
    if (addr_b3 == f_addr) rd = (rd & ~f_clr) | f_set;
    dout3 <= rd;
  end

  // Full-size RAM: fault-free
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we9[i]) mem9[addr_a9][8*i +: 8] <= din9[8*i +: 8];
    dout9 <= mem9[addr_b9];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean run on dut3 starting now; edge 1 samples start. Optional ignored start pulses.
  task automatic run_clean(input int ign_a, input int ign_b);
    int we_cnt;
    we_cnt = 0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    if (ram_we3 == 4'hF) we_cnt++;
    chk("busy_e1", 32'(busy3), 32'd1);
    chk("done_e1", 32'(done3), 32'd0);
    chk("error_e1", 32'(error3), 32'd0);
    chk("errdata_e1", err_data3, 32'd0);
    for (int e = 2; e <= 35; e++) begin
      if (e == ign_a || e == ign_b) start3 = 1'b1;
      tick();
      start3 = 1'b0;
      if (ram_we3 == 4'hF) we_cnt++;
      if (e == 17) chk("pass_e17", 32'(pass_id3), 32'd0);
      if (e == 18) chk("pass_e18", 32'(pass_id3), 32'd1);
      if (e == 34) chk("done_e34", 32'(done3), 32'd0);
    end
    chk("done_e35", 32'(done3), 32'd1);
    chk("error_e35", 32'(error3), 32'd0);
    chk("busy_e35", 32'(busy3), 32'd0);
    chk("we_cycles", 32'(we_cnt), 32'd16);
  endtask

  initial begin
    int e;
    rst = 1'b1; start3 = 1'b0; start9 = 1'b0;
    f_addr = 3'd0; f_clr = '0; f_set = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_done", 32'(done3), 32'd0);
    chk("rst_error", 32'(error3), 32'd0);
    chk("rst_we", 32'(ram_we3), 32'd0);
    chk("rst_err_addr", 32'(err_addr3), 32'd0);
    chk("rst_pass_id", 32'(pass_id3), 32'd0);
    chk("rst_addr_a", 32'(addr_a3), 32'd0);
    rst = 1'b0;
    tick();

    // Clean run with start pulses ignored while busy
    run_clean(4, 20);
    chk("mem5_pass1", mem3[5], 32'hA5A5_FFFA);
    chk("mem0_pass1", mem3[0], 32'hA5A5_FFFF);
    chk("mem7_pass1", mem3[7], 32'hA5A5_FFF8);
    chk("last_addr_a", 32'(addr_a3), 32'd7);
    tick(); tick();
    chk("we_idle", 32'(ram_we3), 32'd0);

    // Restart from PASS
    run_clean(0, 0);

`ifdef RAM_BIST_ERRCNT_EN
    // Bit 31 stuck-at-1 at addr 7: only pass 0 sees it, run goes full length
    f_addr = 3'd7; f_set = 32'h8000_0000;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (e = 2; e <= 35; e++) begin
      tick();
      if (e == 34) chk("cnt_done_e34", 32'(done3), 32'd0);
    end
    chk("cnt_done_e35", 32'(done3), 32'd1);
    chk("cnt_error", 32'(error3), 32'd1);
    chk("cnt_err_count", 32'(err_count3), 32'd1);
    chk("cnt_err_addr", 32'(err_addr3), 32'd7);
    chk("cnt_err_data", err_data3, 32'hDA5A_0007);
    chk("cnt_pass_id", 32'(pass_id3), 32'd0);
    f_set = '0;
`else
    // Bit 0 stuck-at-0 at addr 3: abort in pass 0 when addr 3 is compared (edge 14)
    f_addr = 3'd3; f_clr = 32'h0000_0001;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    e = 1;
    while (!done3 && e < 40) begin
      tick();
      e++;
    end
    chk("fail_edge", 32'(e), 32'd14);
    chk("fail_done", 32'(done3), 32'd1);
    chk("fail_error", 32'(error3), 32'd1);
    chk("fail_busy", 32'(busy3), 32'd0);
    chk("fail_err_addr", 32'(err_addr3), 32'd3);
    chk("fail_err_data", err_data3, 32'h5A5A_0002);
    chk("fail_pass_id", 32'(pass_id3), 32'd0);
    tick(); tick();
    chk("fail_held", 32'(error3), 32'd1);
    f_clr = '0;
`endif

    // Restart from FAIL clears capture state and runs clean
    run_clean(0, 0);
    chk("rerun_err_addr", 32'(err_addr3), 32'd0);
    chk("rerun_pass_id", 32'(pass_id3), 32'd1);

    // Reset mid-run in cycle 10
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (e = 2; e <= 10; e++) tick();
    chk("mid_busy_pre", 32'(busy3), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_busy", 32'(busy3), 32'd0);
    chk("mid_we", 32'(ram_we3), 32'd0);
    chk("mid_done", 32'(done3), 32'd0);
    rst = 1'b0;
    tick();
    run_clean(0, 0);

    // Full-size instance: done after edge 2051
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
    e = 1;
    while (!done9 && e < 3000) begin
      tick();
      e++;
    end
    chk("n512_edge", 32'(e), 32'd2051);
    chk("n512_error", 32'(error9), 32'd0);
    chk("n512_addr_a", 32'(addr_a9), 32'd511);
    chk("n512_err_addr", 32'(err_addr9), 32'd0);
    chk("n512_mem511", mem9[511], 32'hA5A5_FE00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
